// File: rtl/sd_bd_queue_if.sv
// Host/engine signal bundle for the SD buffer-descriptor queue.
// The master side is driven by host and engine; the slave side is the queue itself.
interface sd_bd_queue_if #(
    parameter int DW = 32,
    parameter int AW = 3
);
    logic          flush;
    logic          we_dat;
    logic          we_arg;
    logic [DW-1:0] dat_in_m;
    logic [DW-1:0] arg_in_m;
    logic [AW:0]   free_bd;
    logic [AW:0]   bd_cnt;
    logic          bd_empty;
    logic          re_s;
    logic          ack_o_s;
    logic [DW-1:0] dat_out_s;
    logic [DW-1:0] arg_out_s;
    logic          a_cmp;
    logic [2:0]    err;
    logic          err_clr;

    modport master (
        output flush, we_dat, we_arg, dat_in_m, arg_in_m, re_s, a_cmp, err_clr,
        input  free_bd, bd_cnt, bd_empty, ack_o_s, dat_out_s, arg_out_s, err
    );

    modport slave (
        input  flush, we_dat, we_arg, dat_in_m, arg_in_m, re_s, a_cmp, err_clr,
        output free_bd, bd_cnt, bd_empty, ack_o_s, dat_out_s, arg_out_s, err
    );
endinterface

// File: rtl/sd_bd_queue.sv
// Buffer-descriptor queue: host commits two-word descriptors, the SD engine pops them,
// and each slot is tracked as free, queued or in-flight until the engine signals completion.
module sd_bd_queue #(
    parameter int DW = 32,
    parameter int AW = 3
) (
    input  logic           clk,
    input  logic           rst,
    sd_bd_queue_if.slave   bus
);
    localparam int          DEPTH     = 2 ** AW;
    localparam logic [AW:0] CNT_ZERO  = (AW+1)'(0);
    localparam logic [AW:0] CNT_DEPTH = (AW+1)'(DEPTH);

    logic [2*DW-1:0] ram_r [DEPTH];

    logic [AW-1:0] wr_pnt_r;
    logic [AW-1:0] rd_pnt_r;
    logic [DW-1:0] stage_r;
    logic          staged_r;
    logic [AW:0]   infl_r;
    logic [AW:0]   free_bd_r;
    logic [AW:0]   bd_cnt_r;
    logic          bd_empty_r;
    logic          a_cmp_prev_r;
    logic          ack_r;
    logic [DW-1:0] dat_out_r;
    logic [DW-1:0] arg_out_r;
    logic [2:0]    err_r;

    logic          active_s;
    logic          have_staged_s;
    logic [DW-1:0] addr_word_s;
    logic          commit_s;
    logic          ovf_s;
    logic          seq_wr_s;
    logic          pop_s;
    logic          unf_s;
    logic          rise_s;
    logic          release_s;
    logic          seq_cmp_s;
    logic          staged_nxt_s;
    logic [AW:0]   free_bd_nxt_s;
    logic [AW:0]   bd_cnt_nxt_s;
    logic [AW:0]   infl_nxt_s;
    logic [2:0]    new_err_s;
    logic [2:0]    err_nxt_s;

    // Request decode against registered counters and net-delta counter update
    always_comb begin
        active_s      = ~bus.flush;
        // A same-cycle we_dat supplies the address word directly and counts as staged
        have_staged_s = bus.we_dat | staged_r;
        addr_word_s   = bus.we_dat ? bus.dat_in_m : stage_r;

        commit_s  = active_s & bus.we_arg & have_staged_s & (free_bd_r != CNT_ZERO);
        ovf_s     = active_s & bus.we_arg & have_staged_s & (free_bd_r == CNT_ZERO);
        seq_wr_s  = active_s & bus.we_arg & ~have_staged_s;

        pop_s     = active_s & bus.re_s & (bd_cnt_r != CNT_ZERO);
        unf_s     = active_s & bus.re_s & (bd_cnt_r == CNT_ZERO);

        rise_s    = active_s & bus.a_cmp & ~a_cmp_prev_r;
        release_s = rise_s & (infl_r != CNT_ZERO);
        seq_cmp_s = rise_s & (infl_r == CNT_ZERO);

        if (bus.we_arg) begin
            staged_nxt_s = 1'b0;
        end else if (bus.we_dat) begin
            staged_nxt_s = 1'b1;
        end else begin
            staged_nxt_s = staged_r;
        end

        free_bd_nxt_s = free_bd_r + (AW+1)'(release_s) - (AW+1)'(commit_s);
        bd_cnt_nxt_s  = bd_cnt_r  + (AW+1)'(commit_s)  - (AW+1)'(pop_s);
        infl_nxt_s    = infl_r    + (AW+1)'(pop_s)     - (AW+1)'(release_s);

        new_err_s = {seq_wr_s | seq_cmp_s, unf_s, ovf_s};
        // A fresh error in the clearing cycle survives the clear
        if (bus.err_clr) begin
            err_nxt_s = new_err_s;
        end else begin
            err_nxt_s = err_r | new_err_s;
        end
    end

    // Descriptor storage; contents are intentionally left unreset
    always_ff @(posedge clk) begin
        if (commit_s) begin
            ram_r[wr_pnt_r] <= {addr_word_s, bus.arg_in_m};
        end
    end

    // Pointers, staging, counters and pop outputs; flush behaves as a synchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_pnt_r     <= {AW{1'b0}};
            rd_pnt_r     <= {AW{1'b0}};
            stage_r      <= {DW{1'b0}};
            staged_r     <= 1'b0;
            infl_r       <= CNT_ZERO;
            free_bd_r    <= CNT_DEPTH;
            bd_cnt_r     <= CNT_ZERO;
            bd_empty_r   <= 1'b1;
            a_cmp_prev_r <= 1'b0;
            ack_r        <= 1'b0;
            dat_out_r    <= {DW{1'b0}};
            arg_out_r    <= {DW{1'b0}};
        end else if (bus.flush) begin
            wr_pnt_r     <= {AW{1'b0}};
            rd_pnt_r     <= {AW{1'b0}};
            stage_r      <= {DW{1'b0}};
            staged_r     <= 1'b0;
            infl_r       <= CNT_ZERO;
            free_bd_r    <= CNT_DEPTH;
            bd_cnt_r     <= CNT_ZERO;
            bd_empty_r   <= 1'b1;
            a_cmp_prev_r <= 1'b0;
            ack_r        <= 1'b0;
            dat_out_r    <= {DW{1'b0}};
            arg_out_r    <= {DW{1'b0}};
        end else begin
            if (bus.we_dat) begin
                stage_r <= bus.dat_in_m;
            end
            staged_r     <= staged_nxt_s;
            a_cmp_prev_r <= bus.a_cmp;
            if (commit_s) begin
                wr_pnt_r <= wr_pnt_r + AW'(1);
            end
            ack_r <= pop_s;
            if (pop_s) begin
                rd_pnt_r  <= rd_pnt_r + AW'(1);
                dat_out_r <= ram_r[rd_pnt_r][2*DW-1:DW];
                arg_out_r <= ram_r[rd_pnt_r][DW-1:0];
            end
            infl_r     <= infl_nxt_s;
            free_bd_r  <= free_bd_nxt_s;
            bd_cnt_r   <= bd_cnt_nxt_s;
            bd_empty_r <= (bd_cnt_nxt_s == CNT_ZERO);
        end
    end

    // Sticky error bits survive flush and clear only on reset or err_clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 3'b000;
        end else if (bus.flush) begin
            err_r <= err_r;
        end else begin
            err_r <= err_nxt_s;
        end
    end

    assign bus.free_bd   = free_bd_r;
    assign bus.bd_cnt    = bd_cnt_r;
    assign bus.bd_empty  = bd_empty_r;
    assign bus.ack_o_s   = ack_r;
    assign bus.dat_out_s = dat_out_r;
    assign bus.arg_out_s = arg_out_r;
    assign bus.err       = err_r;
endmodule
